and_gate: RTL and testbench

- Bitwise two-input AND block with a combinational output and a registered, valid-qualified output.
- Used as a basic logic primitive and reference cell for gate-level bring-up and waveform checks.
- Default WIDTH=1 reproduces a plain 2-input AND gate on the combinational port `o`.

---
 rtl/and_gate.sv | 60 ++++++
 tb/tb_and_gate.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/and_gate.sv
// rtl/and_gate.sv - bitwise AND with combinational and registered valid-qualified outputs
// Optional capture hit counter enabled by defining AND_GATE_STATS_EN.
module and_gate #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
`ifdef AND_GATE_STATS_EN
  input  logic             stats_clr,
  output logic [15:0]      hit_count,
`endif
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid,
  output logic             all_ones,
  output logic             any_one
);

  logic [WIDTH-1:0] and_res;

  assign and_res = a & b;
  assign o       = and_res;

  // o_q holds between captures; o_valid is a one-cycle pulse per capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q     <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= in_valid;
      if (in_valid) begin
        o_q <= and_res;
      end
    end
  end

  assign all_ones = &o_q;
  assign any_one  = |o_q;

`ifdef AND_GATE_STATS_EN
  logic hit;

  assign hit = in_valid && (|and_res);

  // clear wins over increment; counter sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (stats_clr) begin
      hit_count <= '0;
    end else if (hit && (hit_count != 16'hFFFF)) begin
      hit_count <= hit_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_and_gate.sv
// tb/tb_and_gate.sv - scoreboard bench for and_gate (WIDTH=1 and WIDTH=8 instances)
// Stats checks are compiled in when AND_GATE_STATS_EN is defined.
module tb_and_gate;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] a1, b1, o1, o_q1;
  logic       in_valid1, o_valid1, all_ones1, any_one1;
  logic [7:0] a8, b8, o8, o_q8;
  logic       in_valid8, o_valid8, all_ones8, any_one8;
`ifdef AND_GATE_STATS_EN
  logic        stats_clr;
  logic [15:0] hit_count1, hit_count8;
  logic [15:0] exp_hits;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] held;

  always #5 clk = ~clk;

  and_gate #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a1),
    .b        (b1),
    .in_valid (in_valid1),
`ifdef AND_GATE_STATS_EN
    .stats_clr(1'b0),
    .hit_count(hit_count1),
`endif
    .o        (o1),
    .o_q      (o_q1),
    .o_valid  (o_valid1),
    .all_ones (all_ones1),
    .any_one  (any_one1)
  );

  and_gate #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a8),
    .b        (b8),
    .in_valid (in_valid8),
`ifdef AND_GATE_STATS_EN
    .stats_clr(stats_clr),
    .hit_count(hit_count8),
`endif
    .o        (o8),
    .o_q      (o_q8),
    .o_valid  (o_valid8),
    .all_ones (all_ones8),
    .any_one  (any_one8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus on the WIDTH=8 instance, with scoreboard push/pop
  task automatic step(input logic [7:0] ta, input logic [7:0] tb_, input logic tv, input logic clr);
    @(negedge clk);
    a8 = ta;
    b8 = tb_;
    in_valid8 = tv;
`ifdef AND_GATE_STATS_EN
    stats_clr = clr;
    if (clr) exp_hits = 16'h0;
    else if (tv && ((ta & tb_) != 8'h00) && exp_hits != 16'hFFFF) exp_hits = exp_hits + 16'd1;
`endif
    #1;
    check("o_comb", o8, ta & tb_);
    if (tv) exp_q.push_back(ta & tb_);
    @(posedge clk);
    #1;
    check("o_valid", o_valid8, tv);
    if (o_valid8 === 1'b1) begin
      if (exp_q.size() > 0) held = exp_q.pop_front();
      else check("sb_underflow", exp_q.size(), 1);
    end
    check("o_q", o_q8, held);
    check("all_ones", all_ones8, &held);
    check("any_one", any_one8, |held);
`ifdef AND_GATE_STATS_EN
    check("hit_count", hit_count8, exp_hits);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; in_valid1 = 1'b0;
    a8 = 8'h5A; b8 = 8'h0F; in_valid8 = 1'b0;
    held = 8'h00;
`ifdef AND_GATE_STATS_EN
    stats_clr = 1'b0;
    exp_hits = 16'h0;
`endif
    #2;
    check("rst_o_q", o_q8, 8'h00);
    check("rst_o_valid", o_valid8, 1'b0);
    check("rst_all_ones", all_ones8, 1'b0);
    check("rst_any_one", any_one8, 1'b0);
    check("rst_o_comb", o8, 8'h0A);
    check("rst_o_q1", o_q1, 1'b0);
    check("rst_flags1", {o_valid1, all_ones1, any_one1}, 3'b000);
`ifdef AND_GATE_STATS_EN
    check("rst_hits", hit_count8, 16'h0);
    check("rst_hits1", hit_count1, 16'h0);
`endif

    // WIDTH=1 truth table, 1 ns spacing
    a1 = 1'b1; b1 = 1'b0; #0; #0; check("and1_10", o1, 1'b0);
    #1; a1 = 1'b0; b1 = 1'b1; #1; check("and1_01", o1, 1'b0);
    a1 = 1'b1; b1 = 1'b1; #1; check("and1_11", o1, 1'b1);
    a1 = 1'b0; b1 = 1'b0; #1; check("and1_00", o1, 1'b0);
    a1 = 1'b1; b1 = 1'b1; #1; check("and1_11b", o1, 1'b1);
    a1 = 1'b1; b1 = 1'bx; #1; check("and1_1x", o1, 1'bx);
    a1 = 1'b0; #1; check("and1_0x", o1, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // capture into WIDTH=1 and then reset asynchronously mid-cycle
    a1 = 1'b1; b1 = 1'b1; in_valid1 = 1'b1;
    step(8'hFF, 8'h81, 1'b1, 1'b0);
    check("w1_capture", o_q1, 1'b1);
    in_valid1 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    held = 8'h00;
    check("arst_o_q1", o_q1, 1'b0);
    check("arst_o_valid1", o_valid1, 1'b0);
    check("arst_o_q8", o_q8, 8'h00);
    check("arst_flags8", {o_valid8, all_ones8, any_one8}, 3'b000);
    a1 = 1'b1; b1 = 1'b1; #1;
    check("arst_o_comb1", o1, 1'b1);
    // capture attempted while reset is held is dropped
    in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    check("arst_drop", o_q8, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid8 = 1'b0;
`ifdef AND_GATE_STATS_EN
    exp_hits = 16'h0;
`endif

    step(8'hF0, 8'h3C, 1'b1, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0);
    step(8'hFF, 8'hFF, 1'b1, 1'b0);
    step(8'hFF, 8'h00, 1'b1, 1'b0);
    step(8'hA5, 8'h0F, 1'b1, 1'b0);
    step(8'h3C, 8'h7E, 1'b1, 1'b0);
    step(8'h81, 8'hC3, 1'b1, 1'b0);
    step(8'h12, 8'h34, 1'b1, 1'b0);
    step(8'h55, 8'hAA, 1'b1, 1'b0);
    step(8'hEE, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      step(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef AND_GATE_STATS_EN
    step(8'h00, 8'h00, 1'b0, 1'b1);
    step(8'h0F, 8'h01, 1'b1, 1'b0);
    step(8'hF0, 8'h0F, 1'b1, 1'b0);
    step(8'hC0, 8'h40, 1'b1, 1'b0);
    step(8'h80, 8'h80, 1'b1, 1'b0);
    check("hits_three", hit_count8, 16'd3);
    step(8'h11, 8'h11, 1'b1, 1'b1);
    check("hits_clr", hit_count8, 16'd0);
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; in_valid8 = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("hits_fffe", hit_count8, 16'hFFFE);
    repeat (6) @(posedge clk);
    #1;
    check("hits_sat", hit_count8, 16'hFFFF);
    held = 8'h01;
    exp_hits = 16'hFFFF;
    step(8'h03, 8'h03, 1'b1, 1'b0);
`endif

    step(8'h00, 8'h00, 1'b0, 1'b0);
    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
